// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          Flush;
  logic          PushValid;
  logic          PushReady;
  logic [31:0]   PushPC;
  logic [31:0]   PushPCPlus4;
  logic [31:0]   PushInstr;
  logic          PopValid;
  logic          PopReady;
  logic [31:0]   PopPC;
  logic [31:0]   PopPCPlus4;
  logic [31:0]   PopInstr;
  logic [AW:0]   Count;

  modport master (
    output Flush, PushValid, PushPC, PushPCPlus4, PushInstr, PopReady,
    input  PushReady, PopValid, PopPC, PopPCPlus4, PopInstr, Count
  );

  modport slave (
    input  Flush, PushValid, PushPC, PushPCPlus4, PushInstr, PopReady,
    output PushReady, PopValid, PopPC, PopPCPlus4, PopInstr, Count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue of {PC, PCPlus4, Instr} packets with flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle fall-through when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, bypass;
  logic          push_fire, pop_fire, wr_en;
  logic [95:0]   head;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && bus.PushValid && !bus.Flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    bus.PushReady  = !full && !rst;
    bus.PopValid   = !empty || bypass;
    bus.Count      = count_q;
    bus.PopPC      = head[95:64];
    bus.PopPCPlus4 = head[63:32];
    bus.PopInstr   = head[31:0];
    if (bypass) begin
      bus.PopPC      = bus.PushPC;
      bus.PopPCPlus4 = bus.PushPCPlus4;
      bus.PopInstr   = bus.PushInstr;
    end else if (empty) begin
      // storage is never reset, so an empty queue must not expose it
      bus.PopPC      = '0;
      bus.PopPCPlus4 = '0;
      bus.PopInstr   = NOP;
    end
  end

  assign push_fire = bus.PushValid && bus.PushReady;
  assign pop_fire  = bus.PopValid && bus.PopReady;

  always_comb begin
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!(bypass && bus.PopReady)) begin
      // a bypassed packet taken by decode this cycle never touches storage
      wr_en = push_fire;
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
      else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {bus.PushPC, bus.PushPCPlus4, bus.PushInstr};
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage.
- Buffers up to DEPTH fetched packets {PC, PCPlus4, Instr} so that fetch can run ahead while decode stalls.
- Uses valid/ready handshakes on both sides.
- A flush input discards all buffered packets when a taken branch, JAL or JALR redirects the PC.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous flush; discards all entries and any same-cycle push.
- PushValid  input  1  fetch side presents a packet.
- PushReady  output  1  queue can accept a packet.
- PushPC  input  32  PC of the fetched instruction.
- PushPCPlus4  input  32  PC+4 of the fetched instruction.
- PushInstr  input  32  fetched instruction word.
- PopValid  output  1  head packet is valid for decode.
- PopReady  input  1  decode consumes the head packet.
- PopPC  output  32  head packet PC.
- PopPCPlus4  output  32  head packet PC+4.
- PopInstr  output  32  head packet instruction.
- Count  output  AW+1  number of valid entries (0..DEPTH).

Behaviour:
- Reset is asynchronous and active-high, and applies immediately on assertion:
  - WrPtr=0, RdPtr=0, Count=0.
  - PopValid=0, PushReady=0 while rst is high; PushReady=1 on the first cycle after deassertion.
- Storage is a circular buffer of DEPTH x 96 bits. Pointers are AW bits and wrap from DEPTH-1 to 0.
- Full = (Count==DEPTH); Empty = (Count==0).
- PushReady = !Full && !rst.
  - There is no push-on-full even with a simultaneous pop; PushReady depends on Count only.
- Push fires when PushValid && PushReady:
  - the packet is written at WrPtr;
  - WrPtr increments.
- Pop fires when PopValid && PopReady:
  - RdPtr increments.
  - PopReady with PopValid=0 has no effect.
- Simultaneous push and pop: both pointers advance and Count is unchanged.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on both or on neither.
- Pop outputs are a combinational read of the entry at RdPtr, so latency is 1 cycle from push to PopValid.
- When Empty (and not bypassing), outputs are forced to PopPC=0, PopPCPlus4=0, PopInstr=32'h00000013 (NOP).
- Flush has priority over push and pop in the same cycle:
  - next state is WrPtr=0, RdPtr=0, Count=0;
  - the same-cycle push is dropped and the same-cycle pop is ignored;
  - PopValid=0 on the next cycle.
- Flush while empty is a no-op apart from resetting the pointers to 0.
- Storage contents are not reset; only the pointers and Count are.
- There are no X on outputs after reset, because of the empty-forcing rule above.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when Empty && PushValid && !Flush:
  - PopValid=1 and the Pop* outputs take the Push* inputs in the same cycle (fall-through, 0-cycle latency).
  - If PopReady is also 1, the packet is consumed directly: no write, pointers and Count unchanged.
  - If PopReady=0, the packet is written normally and Count becomes 1.
- Not defined: there is no combinational path from Push* to Pop*, and the minimum latency is 1 cycle.

Test Plan:
- Reset then idle:
  - PopValid=0, PushReady=1, Count=0, PopInstr=32'h00000013.
  - Assert rst mid-run with Count=3 -> Count=0 and PopValid=0 immediately, with no clock edge.
- Fill with PopReady=0:
  - push PC=0x00,0x04,0x08,0x0C -> Count=4 and PushReady=0.
  - A 5th push with PushValid=1 is not accepted, and the head remains PopPC=0x00.
- Drain in order:
  - from full, PopReady=1 for 4 cycles -> PopPC sequence 0x00,0x04,0x08,0x0C, with PopPCPlus4 = PopPC+4;
  - then Count=0 and PopValid=0.
- Simultaneous push/pop:
  - at Count=2, push 0x10 and pop in the same cycle -> Count stays 2 and the head advances by one.
  - Wrap both pointers through 0 over 10 packets with no data corruption.
- Flush:
  - at Count=3, assert Flush together with PushValid (PC=0x40) and PopReady;
  - next cycle Count=0 and PopValid=0;
  - the next push of PC=0x80 appears as PopPC=0x80.
- Bypass (FETCH_QUEUE_BYPASS_EN defined):
  - empty, push Instr=0x00500093 with PopReady=1 -> PopValid=1 and PopInstr=0x00500093 in the same cycle, with Count staying 0.
  - Without the macro, PopValid rises 1 cycle later.
